// File: rtl/dcache_controller.sv
// ============================================================================
// Module   : dcache_controller
// Brief    : Direct-mapped, write-back, write-allocate data cache with a
//            block-wide req/ack memory port and a pipeline stall output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_controller #(
    parameter int LINES      = 16,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic                  mem_ack_i,
    input  logic [BLOCK_BITS-1:0] mem_data_i
);

    localparam int c_OFF_W  = $clog2(BLOCK_BITS / 8);
    localparam int c_WSEL_W = $clog2(BLOCK_BITS / 32);
    localparam int c_IDX_W  = $clog2(LINES);
    localparam int c_TAG_W  = 32 - c_IDX_W - c_OFF_W;

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_WRITEBACK = 2'd1;
    localparam logic [1:0] c_S_REFILL    = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [c_TAG_W-1:0]    r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    logic                  r_mem_req;
    logic                  r_mem_write;
    logic [31:0]           r_mem_addr;
    logic [BLOCK_BITS-1:0] r_mem_data;

    logic [c_WSEL_W-1:0]   w_wsel;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_TAG_W-1:0]    w_tag;
    logic [BLOCK_BITS-1:0] w_line;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_victim_dirty;
    logic                  w_ack;
    logic                  w_fill;
    logic                  w_write_hit;
    logic [31:0]           w_refill_addr;
    logic [31:0]           w_victim_addr;
    logic                  w_unused_addr_bits;

    assign w_wsel         = cpu_addr_i[c_OFF_W-1:2];
    assign w_idx          = cpu_addr_i[c_OFF_W +: c_IDX_W];
    assign w_tag          = cpu_addr_i[31 -: c_TAG_W];
    assign w_line         = r_data[w_idx];
    assign w_req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_hit          = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss         = w_req & ~w_hit;
    assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
    // An ack only counts while a request is actually outstanding
    assign w_ack          = mem_ack_i & r_mem_req;
    assign w_fill         = (r_state == c_S_REFILL) & w_ack;
    assign w_write_hit    = (r_state == c_S_IDLE) & cpu_MemWrite_i & w_hit;
    assign w_refill_addr  = {w_tag, w_idx, {c_OFF_W{1'b0}}};
    assign w_victim_addr  = {r_tag[w_idx], w_idx, {c_OFF_W{1'b0}}};
    assign w_unused_addr_bits = ^cpu_addr_i[1:0];

    assign mem_req_o   = r_mem_req;
    assign mem_write_o = r_mem_write;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_miss) begin
                    w_next_state = w_victim_dirty ? c_S_WRITEBACK : c_S_REFILL;
                end
            end
            c_S_WRITEBACK: begin
                if (w_ack) begin
                    w_next_state = c_S_REFILL;
                end
            end
            c_S_REFILL: begin
                if (w_ack) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall_o = (r_state != c_S_IDLE) | w_miss;
        cpu_data_o  = 32'h0;
        if ((r_state == c_S_IDLE) && w_hit && cpu_MemRead_i && !cpu_MemWrite_i) begin
            cpu_data_o = w_line[w_wsel*32 +: 32];
        end
    end

    // Memory port registers change only on the edges that enter or leave a transfer
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_data  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_miss) begin
                        r_mem_req <= 1'b1;
                        if (w_victim_dirty) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= w_victim_addr;
                            r_mem_data  <= w_line;
                        end else begin
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= w_refill_addr;
                            r_mem_data  <= '0;
                        end
                    end
                end
                c_S_WRITEBACK: begin
                    if (w_ack) begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= w_refill_addr;
                        r_mem_data  <= '0;
                    end
                end
                c_S_REFILL: begin
                    if (w_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= 32'h0;
                        r_mem_data  <= '0;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage need no reset: the valid bits gate every use
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_data_i;
        end else if (w_write_hit) begin
            r_data[w_idx][w_wsel*32 +: 32] <= cpu_data_i;
        end
    end

endmodule

`default_nettype wire
